// File: rtl/stopwatch_run_ctrl_if.sv
// Key inputs, counter handshake and display outputs of the stopwatch run/lap controller.
// The slave modport is the controller side. The master modport is the board/datapath side.
`timescale 1ns/1ps
interface stopwatch_run_ctrl_if;
  logic        btn_ss;
  logic        btn_lap;
  logic [19:0] cnt_bcd;
  logic        cnt_wrap;
  logic        cnt_en;
  logic        cnt_clr;
  logic [19:0] disp_bcd;
  logic        lap_act;
  logic [1:0]  state;

  modport slave (
    input  btn_ss,
    input  btn_lap,
    input  cnt_bcd,
    input  cnt_wrap,
    output cnt_en,
    output cnt_clr,
    output disp_bcd,
    output lap_act,
    output state
  );

  modport master (
    output btn_ss,
    output btn_lap,
    output cnt_bcd,
    output cnt_wrap,
    input  cnt_en,
    input  cnt_clr,
    input  disp_bcd,
    input  lap_act,
    input  state
  );
endinterface

// File: rtl/stopwatch_run_ctrl.sv
// Run/lap controller for the 000.00-999.99 stopwatch.
// It debounces the start/stop and lap/reset keys and sequences the counter enable and clear.
// It also holds the lap snapshot and selects the live or frozen digits for the display mux.
`timescale 1ns/1ps
module stopwatch_run_ctrl #(
  parameter int unsigned DEB_CNT      = 250000,
  parameter bit          STOP_ON_WRAP = 1'b1
) (
  input logic                 clk,
  input logic                 rst,
  stopwatch_run_ctrl_if.slave bus
);

  localparam int unsigned     CW       = (DEB_CNT > 1) ? $clog2(DEB_CNT) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEB_CNT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    LAP  = 2'b10,
    STOP = 2'b11
  } state_t;

  // Key index 0 = start/stop, 1 = lap/reset
  logic [1:0]    key_raw;
  logic [1:0]    key_s1;
  logic [1:0]    key_sync;
  logic [1:0]    key_deb;
  logic [1:0]    key_deb_q;
  logic [1:0]    key_press;
  logic [CW-1:0] deb_cnt [2];

  logic ss_press;
  logic lap_press;

  state_t      st;
  state_t      st_nxt;
  logic        capture;
  logic        clr_req;
  logic        wrap_stop;

  logic        cnt_en_q;
  logic        cnt_clr_q;
  logic        lap_act_q;
  logic [19:0] disp_q;
  logic [19:0] lap_reg;

  logic        cnt_en_nxt;
  logic        cnt_clr_nxt;
  logic        lap_act_nxt;
  logic [19:0] disp_nxt;
  logic [19:0] lap_reg_nxt;

  assign key_raw = {bus.btn_lap, bus.btn_ss};

  // Synchronize, debounce and edge-detect both keys.
  // The press pulse is registered, so the FSM acts one cycle after deb rises.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_s1    <= '0;
      key_sync  <= '0;
      key_deb   <= '0;
      key_deb_q <= '0;
      key_press <= '0;
      for (int unsigned i = 0; i < 2; i++) begin
        deb_cnt[i] <= '0;
      end
    end else begin
      key_s1    <= key_raw;
      key_sync  <= key_s1;
      key_deb_q <= key_deb;
      key_press <= key_deb & ~key_deb_q;
      for (int unsigned i = 0; i < 2; i++) begin
        if (key_sync[i] == key_deb[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == CNT_LAST) begin
          key_deb[i] <= key_sync[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + CW'(1);
        end
      end
    end
  end

  assign ss_press  = key_press[0];
  assign lap_press = key_press[1];
  assign wrap_stop = STOP_ON_WRAP && bus.cnt_wrap && ((st == RUN) || (st == LAP));

  // State register and registered outputs, loaded from the next-state decode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st        <= IDLE;
      cnt_en_q  <= 1'b0;
      cnt_clr_q <= 1'b0;
      lap_act_q <= 1'b0;
      disp_q    <= '0;
      lap_reg   <= '0;
    end else begin
      st        <= st_nxt;
      cnt_en_q  <= cnt_en_nxt;
      cnt_clr_q <= cnt_clr_nxt;
      lap_act_q <= lap_act_nxt;
      disp_q    <= disp_nxt;
      lap_reg   <= lap_reg_nxt;
    end
  end

  // Next-state decode. Start/stop beats lap, and a counter wrap beats both.
  always_comb begin
    st_nxt  = st;
    capture = 1'b0;
    clr_req = 1'b0;
    case (st)
      IDLE: begin
        if (ss_press) begin
          st_nxt = RUN;
        end else if (lap_press) begin
          st_nxt  = IDLE;
          clr_req = 1'b1;
        end
      end
      RUN: begin
        if (wrap_stop || ss_press) begin
          st_nxt = STOP;
        end else if (lap_press) begin
          st_nxt  = LAP;
          capture = 1'b1;
        end
      end
      LAP: begin
        if (wrap_stop || ss_press) begin
          st_nxt = STOP;
        end else if (lap_press) begin
          st_nxt = RUN;
        end
      end
      STOP: begin
        if (ss_press) begin
          st_nxt = RUN;
        end else if (lap_press) begin
          st_nxt  = IDLE;
          clr_req = 1'b1;
        end
      end
      default: st_nxt = IDLE;
    endcase
  end

  // Output decode from the next state. The display shows the snapshot only while in LAP.
  always_comb begin
    cnt_en_nxt  = (st_nxt == RUN) || (st_nxt == LAP);
    lap_act_nxt = (st_nxt == LAP);
    cnt_clr_nxt = clr_req;
    lap_reg_nxt = capture ? bus.cnt_bcd : lap_reg;
    disp_nxt    = lap_act_nxt ? lap_reg_nxt : bus.cnt_bcd;
  end

  assign bus.cnt_en   = cnt_en_q;
  assign bus.cnt_clr  = cnt_clr_q;
  assign bus.lap_act  = lap_act_q;
  assign bus.disp_bcd = disp_q;
  assign bus.state    = st;

endmodule

// File: tb/tb_stopwatch_run_ctrl.sv
// Directed bench for stopwatch_run_ctrl with DEB_CNT=4 and scoreboard-queued expectations.
`timescale 1ns/1ps
module tb_stopwatch_run_ctrl;

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_RUN  = 2'b01;
  localparam logic [1:0] S_LAP  = 2'b10;
  localparam logic [1:0] S_STOP = 2'b11;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  stopwatch_run_ctrl_if bus ();

  stopwatch_run_ctrl #(
    .DEB_CNT      (4),
    .STOP_ON_WRAP (1'b1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef enum int unsigned {F_STATE, F_EN, F_CLR, F_LAP, F_DISP, F_LAPREG} fld_t;
  typedef struct {
    string       tag;
    fld_t        fld;
    logic [19:0] val;
  } exp_t;

  exp_t        sb [$];
  int unsigned tests = 0;
  int unsigned fails = 0;

  task automatic tick(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input string tag, input fld_t f, input logic [19:0] v);
    exp_t e;
    e.tag = tag;
    e.fld = f;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic push_out(input string tag, input logic [1:0] st, input logic en,
                          input logic clr, input logic la, input logic [19:0] d);
    push({tag, ".state"}, F_STATE, 20'(st));
    push({tag, ".cnt_en"}, F_EN, 20'(en));
    push({tag, ".cnt_clr"}, F_CLR, 20'(clr));
    push({tag, ".lap_act"}, F_LAP, 20'(la));
    push({tag, ".disp_bcd"}, F_DISP, d);
  endtask

  function automatic logic [19:0] observe(input fld_t f);
    case (f)
      F_STATE:  return 20'(bus.state);
      F_EN:     return 20'(bus.cnt_en);
      F_CLR:    return 20'(bus.cnt_clr);
      F_LAP:    return 20'(bus.lap_act);
      F_DISP:   return bus.disp_bcd;
      F_LAPREG: return dut.lap_reg;
      default:  return '0;
    endcase
  endfunction

  task automatic check();
    exp_t        e;
    logic [19:0] obs;
    while (sb.size() != 0) begin
      e   = sb.pop_front();
      obs = observe(e.fld);
      tests++;
      assert (obs === e.val) else begin
        fails++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic press(input logic ss, input logic lp, input int unsigned hold,
                       input int unsigned gap);
    bus.btn_ss  = ss;
    bus.btn_lap = lp;
    tick(hold);
    bus.btn_ss  = 1'b0;
    bus.btn_lap = 1'b0;
    tick(gap);
  endtask

  // A lap press that must land in IDLE with exactly one cycle of cnt_clr
  task automatic lap_clr(input string tag, input logic [1:0] from_st, input logic [19:0] d);
    bus.btn_lap = 1'b1;
    tick(6);
    bus.btn_lap = 1'b0;
    tick(1);
    push_out({tag, "_pre"}, from_st, 1'b0, 1'b0, 1'b0, d);
    check();
    tick(1);
    push_out({tag, "_on"}, S_IDLE, 1'b0, 1'b1, 1'b0, d);
    check();
    tick(1);
    push_out({tag, "_off"}, S_IDLE, 1'b0, 1'b0, 1'b0, d);
    check();
    tick(8);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [19:0] ramp [5];
    ramp = '{20'h00124, 20'h00125, 20'h00126, 20'h00127, 20'h00128};

    rst          = 1'b1;
    bus.btn_ss   = 1'b0;
    bus.btn_lap  = 1'b0;
    bus.cnt_bcd  = '0;
    bus.cnt_wrap = 1'b0;

    // Reset
    tick(3);
    push_out("rst", S_IDLE, 1'b0, 1'b0, 1'b0, 20'h00000);
    push("rst.lap_reg", F_LAPREG, 20'h00000);
    check();
    rst         = 1'b0;
    bus.cnt_bcd = 20'h00042;
    tick(1);
    push_out("idle_live", S_IDLE, 1'b0, 1'b0, 1'b0, 20'h00042);
    check();

    // Start latency: the state changes on the 8th edge after the key goes high
    bus.btn_ss = 1'b1;
    tick(7);
    push_out("ss_pre", S_IDLE, 1'b0, 1'b0, 1'b0, 20'h00042);
    check();
    tick(1);
    push_out("ss_run", S_RUN, 1'b1, 1'b0, 1'b0, 20'h00042);
    check();
    tick(2);
    bus.btn_ss = 1'b0;
    tick(10);
    push_out("ss_held_once", S_RUN, 1'b1, 1'b0, 1'b0, 20'h00042);
    check();
    press(1'b1, 1'b0, 6, 8);
    push_out("ss_stop", S_STOP, 1'b0, 1'b0, 1'b0, 20'h00042);
    check();

    // Clear pulses from STOP and from IDLE
    lap_clr("stop_clr", S_STOP, 20'h00042);
    lap_clr("idle_clr", S_IDLE, 20'h00042);

    // Glitch is rejected, then the minimum hold is accepted
    press(1'b1, 1'b0, 3, 10);
    push_out("glitch", S_IDLE, 1'b0, 1'b0, 1'b0, 20'h00042);
    check();
    press(1'b1, 1'b0, 4, 8);
    push_out("hold4", S_RUN, 1'b1, 1'b0, 1'b0, 20'h00042);
    check();

    // Lap snapshot freezes the display
    bus.cnt_bcd = 20'h00123;
    press(1'b0, 1'b1, 6, 8);
    push_out("lap_enter", S_LAP, 1'b1, 1'b0, 1'b1, 20'h00123);
    push("lap_enter.lap_reg", F_LAPREG, 20'h00123);
    check();
    for (int i = 0; i < 5; i++) begin
      bus.cnt_bcd = ramp[i];
      tick(1);
      push("lap_freeze", F_DISP, 20'h00123);
      check();
    end
    press(1'b0, 1'b1, 6, 8);
    push_out("lap_release", S_RUN, 1'b1, 1'b0, 1'b0, 20'h00128);
    check();
    bus.cnt_bcd = 20'h00200;
    tick(1);
    bus.cnt_bcd = 20'h00201;
    push("follow_a", F_DISP, 20'h00200);
    check();
    tick(1);
    push("follow_b", F_DISP, 20'h00201);
    check();

    // Both keys in the same cycle: stop wins, no capture
    bus.cnt_bcd = 20'h45678;
    press(1'b1, 1'b1, 6, 8);
    push_out("both", S_STOP, 1'b0, 1'b0, 1'b0, 20'h45678);
    push("both.lap_reg", F_LAPREG, 20'h00123);
    check();

    // Counter wrap while in LAP forces STOP
    press(1'b1, 1'b0, 6, 8);
    bus.cnt_bcd = 20'h00555;
    press(1'b0, 1'b1, 6, 8);
    push_out("lap2", S_LAP, 1'b1, 1'b0, 1'b1, 20'h00555);
    check();
    bus.cnt_bcd  = 20'h99999;
    bus.cnt_wrap = 1'b1;
    tick(1);
    bus.cnt_wrap = 1'b0;
    push_out("wrap", S_STOP, 1'b0, 1'b0, 1'b0, 20'h99999);
    check();

    // Asynchronous reset in LAP with a start press half debounced
    press(1'b1, 1'b0, 6, 8);
    bus.cnt_bcd = 20'h31415;
    press(1'b0, 1'b1, 6, 8);
    push_out("lap3", S_LAP, 1'b1, 1'b0, 1'b1, 20'h31415);
    push("lap3.lap_reg", F_LAPREG, 20'h31415);
    check();
    bus.btn_ss = 1'b1;
    tick(2);
    rst = 1'b1;
    #1;
    push_out("rst_async", S_IDLE, 1'b0, 1'b0, 1'b0, 20'h00000);
    push("rst_async.lap_reg", F_LAPREG, 20'h00000);
    check();
    bus.btn_ss = 1'b0;
    tick(1);
    rst = 1'b0;
    tick(12);
    push_out("post_rst", S_IDLE, 1'b0, 1'b0, 1'b0, 20'h31415);
    check();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
